// File: rtl/fifo_uart_tx_if.sv
// FIFO read-side handshake between the capture FIFO and its UART drain stage.
// The drain acts as master: it requests reads and snoops the FIFO write strobe.
interface fifo_uart_tx_if #(
  parameter int WIDTH = 16
) ();
  logic             fifo_empty;
  logic             fifo_write_en;
  logic [WIDTH-1:0] fifo_read_data;
  logic             fifo_read_en;

  modport master (
    input  fifo_empty,
    input  fifo_write_en,
    input  fifo_read_data,
    output fifo_read_en
  );

  modport slave (
    output fifo_empty,
    input  fifo_write_en,
    output fifo_read_data,
    input  fifo_read_en
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// Pops WIDTH-bit words from the capture FIFO and sends them MSB byte first as 8N1 UART frames.
// All outputs are registered from the next-state decode, so no input reaches an output combinationally.
module fifo_uart_tx #(
  parameter int WIDTH   = 16,
  parameter int CLK_DIV = 434
) (
  input  logic           clk,
  input  logic           rst,
  fifo_uart_tx_if.master fifo,
  output logic           tx,
  output logic           busy,
  output logic [15:0]    words_sent
);

  localparam int NBYTES = WIDTH / 8;
  localparam int BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BYTE_W = $clog2(NBYTES) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_RELEASE, S_START, S_DATA, S_STOP
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [BAUD_W-1:0] r_baud;
  logic [BAUD_W-1:0] w_baud_nxt;
  logic [2:0]        r_bit;
  logic [2:0]        w_bit_nxt;
  logic [BYTE_W-1:0] r_byte;
  logic [WIDTH-1:0]  r_word;
  logic [15:0]       r_words;
  logic              r_tx;
  logic              r_read_en;
  logic              r_busy;
  logic              w_tx_nxt;
  logic              w_read_en_nxt;
  logic              w_busy_nxt;
  logic              w_baud_done;
  logic              w_last_byte;
  logic              w_byte_next;
  logic              w_word_done;
  logic              w_in_frame;
  logic [7:0]        w_cur_byte;

  assign w_baud_done = (r_baud == BAUD_W'(CLK_DIV - 1));
  assign w_last_byte = (r_byte == BYTE_W'(NBYTES - 1));
  assign w_byte_next = (r_state == S_STOP) && w_baud_done && !w_last_byte;
  assign w_word_done = (r_state == S_STOP) && w_baud_done && w_last_byte;
  assign w_in_frame  = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP);
  assign w_cur_byte  = r_word[WIDTH-1 -: 8];

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FETCH and RELEASE wait out FIFO writes, which pre-empt reads and pointer advances.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (!fifo.fifo_empty)    w_state_nxt = S_FETCH;
      S_FETCH:   if (!fifo.fifo_write_en) w_state_nxt = S_LATCH;
      S_LATCH:                            w_state_nxt = S_RELEASE;
      S_RELEASE: if (!fifo.fifo_write_en) w_state_nxt = S_START;
      S_START:   if (w_baud_done)         w_state_nxt = S_DATA;
      S_DATA:    if (w_baud_done && (r_bit == 3'd7)) w_state_nxt = S_STOP;
      S_STOP:    if (w_baud_done)         w_state_nxt = w_last_byte ? S_IDLE : S_START;
      default:                            w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_baud_nxt = '0;
    if (w_in_frame && !w_baud_done) w_baud_nxt = r_baud + BAUD_W'(1);
    w_bit_nxt = 3'd0;
    if (r_state == S_DATA) w_bit_nxt = w_baud_done ? (r_bit + 3'd1) : r_bit;
  end

  always_comb begin
    w_tx_nxt      = 1'b1;
    w_read_en_nxt = 1'b0;
    w_busy_nxt    = 1'b1;
    case (w_state_nxt)
      S_IDLE:           w_busy_nxt    = 1'b0;
      S_FETCH, S_LATCH: w_read_en_nxt = 1'b1;
      S_START:          w_tx_nxt      = 1'b0;
      S_DATA:           w_tx_nxt      = w_cur_byte[w_bit_nxt];
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx      <= 1'b1;
      r_read_en <= 1'b0;
      r_busy    <= 1'b0;
      r_baud    <= '0;
      r_bit     <= '0;
      r_byte    <= '0;
      r_words   <= '0;
    end else begin
      r_tx      <= w_tx_nxt;
      r_read_en <= w_read_en_nxt;
      r_busy    <= w_busy_nxt;
      r_baud    <= w_baud_nxt;
      r_bit     <= w_bit_nxt;
      if (r_state == S_IDLE || w_word_done) r_byte <= '0;
      else if (w_byte_next)                 r_byte <= r_byte + BYTE_W'(1);
      if (w_word_done) r_words <= r_words + 16'd1;
    end
  end

  // Word register: loaded while the FIFO hold presents data, shifted up one byte per frame.
  always_ff @(posedge clk) begin
    if (r_state == S_LATCH) r_word <= fifo.fifo_read_data;
    else if (w_byte_next)   r_word <= r_word << 8;
  end

  assign tx                = r_tx;
  assign busy              = r_busy;
  assign words_sent        = r_words;
  assign fifo.fifo_read_en = r_read_en;

endmodule
